// File: rtl/syzygy_adc_word_align_pkg.sv
// Shared types and helpers for the SYZYGY ADC word aligner and its output buffer.
package syzygy_adc_word_align_pkg;

    localparam int SAMPLE_W = 16;
    localparam int LANE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Lane A carries the odd sample bits, lane B the even ones.
    function automatic logic [SAMPLE_W-1:0] interleave(
        input logic [LANE_W-1:0] a,
        input logic [LANE_W-1:0] b
    );
        logic [SAMPLE_W-1:0] s;
        s = '0;
        for (int k = 0; k < LANE_W; k++) begin
            s[2*k+1] = a[k];
            s[2*k]   = b[k];
        end
        return s;
    endfunction

endpackage

// File: rtl/syzygy_skid_fifo.sv
// Two-entry output buffer; the head register feeds the consumer directly, so a
// push into an empty buffer is visible right after the write edge.
module syzygy_skid_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             drop
);
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count;
    logic             do_pop;

    assign do_pop = pop && (count != 2'd0);
    // A pop in the same cycle frees a slot, so a full buffer only drops without one.
    assign drop   = push && (count == 2'd2) && !do_pop;
    assign head   = head_q;
    assign valid  = (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head_q <= push_data;
                        count  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (do_pop && push) begin
                        head_q <= push_data;
                    end else if (do_pop) begin
                        count <= 2'd0;
                    end else if (push) begin
                        tail_q <= push_data;
                        count  <= 2'd2;
                    end
                end
                default: begin
                    if (do_pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= push_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/syzygy_adc_word_align.sv
// Two-lane SYZYGY ADC word aligner: bitslip alignment, lane interleave, lock FSM
// with flush after lock start or slip change, and a 2-entry output buffer.
module syzygy_adc_word_align
    import syzygy_adc_word_align_pkg::*;
#(
    parameter int FLUSH_WORDS = 2
) (
    input  logic                slow_clk,
    input  logic                reset_n,
    input  logic                data_valid,
    input  logic [3:0]          bitslip_count,
    input  logic [LANE_W-1:0]   lane_a,
    input  logic [LANE_W-1:0]   lane_b,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                locked,
    output logic                overflow,
    input  logic                clear_overflow,
    output state_t              fsm_state
);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_WORDS);

    logic [1:0]          rst_sync;
    logic                rst_int;
    logic [LANE_W-1:0]   prev_a;
    logic [LANE_W-1:0]   prev_b;
    logic [2*LANE_W-1:0] cat_a;
    logic [2*LANE_W-1:0] cat_b;
    logic [LANE_W-1:0]   aligned_a;
    logic [LANE_W-1:0]   aligned_b;
    logic [2:0]          slip;
    logic [2:0]          slip_q;
    logic                slip_change;
    logic [SAMPLE_W-1:0] sample_q;
    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic [3:0]          cnt_next;
    logic                locked_q;
    logic                overflow_q;
    logic                push;
    logic                pop;
    logic                drop;
    logic                unused_slip_msb;

    // Assertion is immediate; release reaches the core two edges later.
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_int = rst_sync[1];

    assign slip            = bitslip_count[2:0];
    assign unused_slip_msb = bitslip_count[3];
    assign slip_change     = (slip != slip_q);

    assign cat_a     = {prev_a, lane_a};
    assign cat_b     = {prev_b, lane_b};
    assign aligned_a = LANE_W'(cat_a >> slip);
    assign aligned_b = LANE_W'(cat_b >> slip);

    always_ff @(posedge slow_clk or negedge rst_int) begin
        if (!rst_int) begin
            prev_a   <= '0;
            prev_b   <= '0;
            slip_q   <= '0;
            sample_q <= '0;
        end else begin
            prev_a   <= lane_a;
            prev_b   <= lane_b;
            slip_q   <= slip;
            sample_q <= interleave(aligned_a, aligned_b);
        end
    end

    // Losing data_valid outranks a slip change: the lock restarts from IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!data_valid) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_FLUSH;
                    cnt_next   = FLUSH_LOAD;
                end
                ST_FLUSH: begin
                    if (slip_change) begin
                        cnt_next = FLUSH_LOAD;
                    end else if (cnt == 4'd1) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
                ST_RUN: begin
                    if (slip_change) begin
                        state_next = ST_FLUSH;
                        cnt_next   = FLUSH_LOAD;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge slow_clk or negedge rst_int) begin
        if (!rst_int) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            locked_q <= (state_next == ST_RUN);
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Handshake: a sample transfers on a rising edge where sample_valid and
    // sample_ready are both high; sample_data holds while valid && !ready.
    assign push = (state == ST_RUN);
    assign pop  = sample_valid && sample_ready;

    syzygy_skid_fifo #(
        .WIDTH(SAMPLE_W)
    ) u_fifo (
        .clk       (slow_clk),
        .rst_n     (rst_int),
        .push      (push),
        .push_data (sample_q),
        .pop       (pop),
        .head      (sample_data),
        .valid     (sample_valid),
        .drop      (drop)
    );

    assign locked    = locked_q;
    assign overflow  = overflow_q;
    assign fsm_state = state;

endmodule

// File: doc/syzygy_adc_word_align.md
SYZYGY_ADC_WORD_ALIGN -- requirements
Module: syzygy_adc_word_align

Interface
REQ-001 SHALL have parameter FLUSH_WORDS, default 2: words discarded after lock start or bitslip change (range 1-15).
REQ-002 SHALL have port slow_clk  in  1: divided ADC clock; ISERDES word rate; sole clock.
REQ-003 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port data_valid  in  1: frame alignment done; words usable while high.
REQ-005 SHALL have port bitslip_count  in  4: frame-derived bit offset; only bits [2:0] are used.
REQ-006 SHALL have port lane_a  in  8: ISERDES Q of data lane A, MSB first in time.
REQ-007 SHALL have port lane_b  in  8: ISERDES Q of data lane B, MSB first in time.
REQ-008 SHALL have port sample_data  out  16: assembled sample.
REQ-009 SHALL have port sample_valid  out  1: sample_data holds a sample.
REQ-010 SHALL have port sample_ready  in  1: consumer accepts when sample_valid && sample_ready at a rising edge.
REQ-011 SHALL have port locked  out  1: high in RUN state.
REQ-012 SHALL have port overflow  out  1: sticky; a sample was dropped.
REQ-013 SHALL have port clear_overflow  in  1: synchronous clear of overflow.

Function
REQ-014 Each slow_clk edge SHALL register lane_a and lane_b into prev_a and prev_b unconditionally.
REQ-015 Alignment SHALL compute s = bitslip_count[2:0] and aligned_x = {prev_x, lane_x}[s+7:s] for lanes A and B; s=0 yields lane_x.
REQ-016 Assembly SHALL set sample[2k+1] = aligned_a[k] and sample[2k] = aligned_b[k] for k = 0..7, and register the result (stage 2).
REQ-017 The FSM SHALL have three states: IDLE, FLUSH, RUN.
REQ-018 IDLE: transition to FLUSH when data_valid=1, loading the flush counter with FLUSH_WORDS.
REQ-019 FLUSH: decrement the counter each cycle; discard stage-2 output; transition to RUN when the counter reaches 1.
REQ-020 RUN: push each stage-2 sample into the output buffer.
REQ-021 In any state, data_valid=0 SHALL force IDLE on the next edge; samples already in the buffer SHALL be retained.
REQ-022 In RUN or FLUSH, a change of bitslip_count[2:0] from the previous cycle SHALL force FLUSH with the counter reloaded.
REQ-023 Data_valid falling and a bitslip change in the same cycle: IDLE SHALL take priority.
REQ-024 Latency: a word present at edge N SHALL appear on sample_data/sample_valid after edge N+2 when the buffer is empty (buffer write is bypass-registered).
REQ-025 Output buffer: 2-entry FIFO; sample_valid = not empty; sample_data = head entry, unchanged while sample_valid && !sample_ready.
REQ-026 Push and pop in the same cycle with the buffer full SHALL succeed with no drop.
REQ-027 Push with the buffer full and no pop SHALL drop the new sample and set overflow.
REQ-028 Overflow SHALL stay set until clear_overflow=1; a same-cycle set and clear SHALL leave overflow=1.
REQ-029 locked SHALL be registered and equal (state==RUN).

Reset
REQ-030 reset_n=0 SHALL asynchronously force: state IDLE, flush counter 0, prev_a/prev_b 0, stage-2 register 0, FIFO empty, sample_data 0, sample_valid 0, locked 0, overflow 0.
REQ-031 Reset deassertion SHALL be synchronized internally (2-flop) before the FSM leaves IDLE.
REQ-032 Reset mid-stream SHALL discard all buffered samples; no partial sample SHALL emerge after release.

Structure
REQ-033 A shared package SHALL hold: FSM state enum (IDLE/FLUSH/RUN), SAMPLE_W=16, LANE_W=8, and the interleave bit-map function.
REQ-034 The 2-entry FIFO SHALL be a sub-module named syzygy_skid_fifo (parameter width), reusable for other channels.
REQ-035 Alignment and assembly SHALL remain inline; there SHALL be no other sub-modules.

Verification
REQ-036 Test: s=0, data_valid high, lanes A=8'hFF and B=8'h00 constant -> after 2 flush words, sample_data=16'hAAAA, locked=1.
REQ-037 Test: s=3, prev_a=8'hA5 then lane_a=8'h3C, lane_b=8'h00 -> aligned_a=8'hA7 and the sample odd bits carry 8'hA7.
REQ-038 Test: sample_ready held low in RUN -> exactly 2 samples held, 3rd dropped, overflow=1; clear_overflow pulse -> overflow=0.
REQ-039 Test: bitslip_count changes 2->5 in RUN -> locked=0 next cycle, FLUSH_WORDS samples discarded, then locked=1.
REQ-040 Test: data_valid drops with the buffer holding 1 sample -> state IDLE, sample still delivered on sample_ready.
REQ-041 Test: reset_n pulsed low for 1 cycle mid-RUN with the buffer full -> all outputs 0 immediately; relock needs FLUSH_WORDS+sync cycles.
